mem_dp_be: RTL

- Parametrised successor of the single-port 32-bit RAM: generic data width and depth, byte-lane write strobes, a second read-only port, and selectable read latency.
- Read-during-write behaviour is selectable by parameter.
- Sits under instruction/data fetch paths. Port A serves load/store; port B serves instruction fetch or debug readout.
- Read handshake: each read request produces a matching valid pulse.

---
 rtl/mem_dp_be_if.sv | 26 ++
 rtl/mem_dp_be.sv | 82 ++++++++
 2 files changed

// File: rtl/mem_dp_be_if.sv
// mem_dp_be_if: port A read/write bus and port B read-only bus of the dual-port RAM
interface mem_dp_be_if #(
    parameter int ADDR_LEN   = 11,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_LEN-1:0]     a_addr;
    logic                    a_rd_req;
    logic                    a_wr_req;
    logic [DATA_WIDTH/8-1:0] a_wr_be;
    logic [DATA_WIDTH-1:0]   a_wr_data;
    logic [DATA_WIDTH-1:0]   a_rd_data;
    logic                    a_rd_valid;
    logic [ADDR_LEN-1:0]     b_addr;
    logic                    b_rd_req;
    logic [DATA_WIDTH-1:0]   b_rd_data;
    logic                    b_rd_valid;

    modport master (
        output a_addr, a_rd_req, a_wr_req, a_wr_be, a_wr_data, b_addr, b_rd_req,
        input  a_rd_data, a_rd_valid, b_rd_data, b_rd_valid
    );
    modport slave (
        input  a_addr, a_rd_req, a_wr_req, a_wr_be, a_wr_data, b_addr, b_rd_req,
        output a_rd_data, a_rd_valid, b_rd_data, b_rd_valid
    );
endinterface

// File: rtl/mem_dp_be.sv
// mem_dp_be: byte-lane RAM, port A read/write, port B read-only, latency 1 or 2, selectable read-during-write
module mem_dp_be #(
    parameter int ADDR_LEN   = 11,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input logic clk,
    input logic rst,
    mem_dp_be_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $fatal(1, "mem_dp_be: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $fatal(1, "mem_dp_be: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem [1<<ADDR_LEN];
    logic [DATA_WIDTH-1:0] mask, a_old, a_new, b_old, a_rd, b_rd;
    logic [DATA_WIDTH-1:0] a_d1, b_d1;
    logic                  a_v1, b_v1, wr;

    for (genvar i = 0; i < NB; i++) begin : g_mask
        assign mask[8*i +: 8] = {8{bus.a_wr_be[i]}};
    end

    assign wr    = bus.a_wr_req && !rst;
    assign a_old = mem[bus.a_addr];
    assign b_old = mem[bus.b_addr];
    assign a_new = (bus.a_wr_data & mask) | (a_old & ~mask);
    // write-first forwards the merged word to any reader of the address being written
    assign a_rd  = (RDW_MODE == 1 && wr) ? a_new : a_old;
    assign b_rd  = (RDW_MODE == 1 && wr && bus.b_addr == bus.a_addr) ? a_new : b_old;

    always_ff @(posedge clk) begin
        if (wr) mem[bus.a_addr] <= a_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_d1 <= '0;
            b_d1 <= '0;
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
        end else begin
            a_v1 <= bus.a_rd_req;
            b_v1 <= bus.b_rd_req;
            if (bus.a_rd_req) a_d1 <= a_rd;
            if (bus.b_rd_req) b_d1 <= b_rd;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] a_d2, b_d2;
        logic                  a_v2, b_v2;
        always_ff @(posedge clk) begin
            if (rst) begin
                a_d2 <= '0;
                b_d2 <= '0;
                a_v2 <= 1'b0;
                b_v2 <= 1'b0;
            end else begin
                a_v2 <= a_v1;
                b_v2 <= b_v1;
                if (a_v1) a_d2 <= a_d1;
                if (b_v1) b_d2 <= b_d1;
            end
        end
        assign bus.a_rd_data  = a_d2;
        assign bus.a_rd_valid = a_v2;
        assign bus.b_rd_data  = b_d2;
        assign bus.b_rd_valid = b_v2;
    end else begin : g_lat1
        assign bus.a_rd_data  = a_d1;
        assign bus.a_rd_valid = a_v1;
        assign bus.b_rd_data  = b_d1;
        assign bus.b_rd_valid = b_v1;
    end
endmodule
